// File: rtl/mem_access_pkg.sv
// Shared types for the memory access unit: request kinds, FSM states, byte-lane helper.
// The RMW state exists only when MEM_BYTE_EN is defined.
package mem_access_pkg;

    typedef enum logic [1:0] {
        KIND_FETCH = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2,
        KIND_RSVD  = 2'd3
    } kind_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
`ifdef MEM_BYTE_EN
        RMW   = 3'd2,
`endif
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_e;

    // Little-endian lane pick: lane n is bits 8n+7:8n, then sign- or zero-extend.
    function automatic logic [31:0] lane_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic        zext);
        logic [7:0] b;
        b = word[{lane, 3'b000} +: 8];
        return zext ? {24'h000000, b} : {{24{b[7]}}, b};
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake bundle between a requester (master) and the access unit (slave).
interface mem_access_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic        req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_fault;

    modport master (
        output req_valid, req_kind, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_fault
    );

    modport slave (
        input  req_valid, req_kind, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_data, resp_fault
    );

endinterface

// File: rtl/mem_byte_lane.sv
// Byte-lane datapath: extract/extend a loaded byte and merge a store byte into a read word.
module mem_byte_lane
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic        zext,
    input  logic [7:0]  wbyte,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    always_comb begin
        load_val = lane_extend(rdata, lane, zext);
        merged   = rdata;
        merged[{lane, 3'b000} +: 8] = wbyte;
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle memory access unit: FETCH/LOAD/STORE with fault screening and IR/MDR registers.
// Byte accesses (read-modify-write stores) are built only when MEM_BYTE_EN is defined.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned RAM_SIZE_BIT = 8
) (
    input  logic                clk,
    input  logic                reset,
    mem_access_unit_if.slave    bus,
    output logic [31:0]         ir,
    output logic [31:0]         mdr,
    output logic [31:0]         Address,
    output logic [31:0]         Write_data,
    output logic                MemRead,
    output logic                MemWrite,
    input  logic [31:0]         Mem_data
);

    localparam logic [32:0] ADDR_LIMIT = 33'd4 << RAM_SIZE_BIT;

    state_e      state;
    kind_e       req_kind;
    logic        req_fault;
    logic        lat_fetch;
    logic        resp_valid_q;
    logic        resp_fault_q;
    logic [31:0] resp_data_q;
    logic [31:0] load_val;
    logic [31:0] aligned_addr;

    assign req_kind     = kind_e'(bus.req_kind);
    assign aligned_addr = {bus.req_addr[31:2], 2'b00};

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_fault = resp_fault_q;
    assign bus.resp_data  = resp_data_q;

`ifdef MEM_BYTE_EN
    logic        lat_byte;
    logic        lat_unsigned;
    logic [1:0]  lat_lane;
    logic [7:0]  lat_wbyte;
    logic [31:0] lane_load;
    logic [31:0] lane_merged;

    mem_byte_lane u_byte_lane (
        .rdata    (Mem_data),
        .lane     (lat_lane),
        .zext     (lat_unsigned),
        .wbyte    (lat_wbyte),
        .load_val (lane_load),
        .merged   (lane_merged)
    );

    assign load_val = lat_byte ? lane_load : Mem_data;
`else
    logic unused_req_bits;
    assign unused_req_bits = bus.req_unsigned;
    assign load_val        = Mem_data;
`endif

    always_comb begin
        req_fault = 1'b0;
        if (req_kind == KIND_RSVD)                          req_fault = 1'b1;
        if (!bus.req_size && bus.req_addr[1:0] != 2'b00)    req_fault = 1'b1;
        if (req_kind == KIND_FETCH && bus.req_size)         req_fault = 1'b1;
        if ({1'b0, bus.req_addr} >= ADDR_LIMIT)             req_fault = 1'b1;
`ifndef MEM_BYTE_EN
        if (bus.req_size)                                   req_fault = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ir           <= '0;
            mdr          <= '0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_data_q  <= '0;
            MemRead      <= 1'b0;
            MemWrite     <= 1'b0;
            Address      <= '0;
            Write_data   <= '0;
            lat_fetch    <= 1'b0;
`ifdef MEM_BYTE_EN
            lat_byte     <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_lane     <= '0;
            lat_wbyte    <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: if (bus.req_valid) begin
                    lat_fetch <= (req_kind == KIND_FETCH);
`ifdef MEM_BYTE_EN
                    lat_byte     <= bus.req_size;
                    lat_unsigned <= bus.req_unsigned;
                    lat_lane     <= bus.req_addr[1:0];
                    lat_wbyte    <= bus.req_wdata[7:0];
`endif
                    if (req_fault) begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_fault_q <= 1'b1;
                        resp_data_q  <= '0;
                    end else if (req_kind == KIND_STORE) begin
                        Address <= aligned_addr;
`ifdef MEM_BYTE_EN
                        if (bus.req_size) begin
                            state   <= RMW;
                            MemRead <= 1'b1;
                        end else
`endif
                        begin
                            state      <= WRITE;
                            MemWrite   <= 1'b1;
                            Write_data <= bus.req_wdata;
                        end
                    end else begin
                        state   <= READ;
                        MemRead <= 1'b1;
                        Address <= aligned_addr;
                    end
                end
                READ: begin
                    MemRead      <= 1'b0;
                    Address      <= '0;
                    state        <= RESP;
                    resp_valid_q <= 1'b1;
                    if (lat_fetch) begin
                        ir          <= Mem_data;
                        resp_data_q <= Mem_data;
                    end else begin
                        mdr         <= load_val;
                        resp_data_q <= load_val;
                    end
                end
`ifdef MEM_BYTE_EN
                // Address stays put: the merged word goes back to the word just read.
                RMW: begin
                    MemRead    <= 1'b0;
                    MemWrite   <= 1'b1;
                    Write_data <= lane_merged;
                    state      <= WRITE;
                end
`endif
                WRITE: begin
                    MemWrite     <= 1'b0;
                    Address      <= '0;
                    Write_data   <= '0;
                    state        <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_data_q  <= '0;
                end
                RESP: if (bus.resp_ready) begin
                    resp_valid_q <= 1'b0;
                    resp_fault_q <= 1'b0;
                    resp_data_q  <= '0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word memory model.
// Byte-access scenarios are selected by MEM_BYTE_EN, matching the RTL build.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ir, mdr, Address, Write_data, Mem_data;
    logic        MemRead, MemWrite;

    logic [31:0] mem [0:255];
    logic        load_mem = 1'b1;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          overlap = 0;
    int          idle_bus = 0;

    mem_access_unit_if bus ();

    mem_access_unit #(.RAM_SIZE_BIT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .ir         (ir),
        .mdr        (mdr),
        .Address    (Address),
        .Write_data (Write_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Mem_data   (Mem_data)
    );

    always #5 clk = ~clk;

    assign Mem_data = mem[Address[9:2]];

    always @(posedge clk) begin
        if (load_mem) begin
            mem[0]  <= 32'h20040005;
            mem[16] <= 32'h11223344;
            mem[32] <= 32'h00000000;
            mem[33] <= 32'h00000000;
        end else if (MemWrite) begin
            mem[Address[9:2]] <= Write_data;
        end
    end

    always @(negedge clk) begin
        if (MemRead && MemWrite) overlap++;
        if (!MemRead && !MemWrite && (Address != 0 || Write_data != 0)) idle_bus++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request; returns response latency (cycles after handshake), first MemRead cycle,
    // MemRead/MemWrite cycle counts and the response. Holds resp_ready low for 'hold' cycles.
    task automatic do_req(input logic [1:0] kind, input logic size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                          output int lat, output int first_rd, output int nrd, output int nwr,
                          output logic [31:0] data, output logic flt);
        @(negedge clk);
        bus.req_kind     = kind;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        bus.resp_ready   = 1'b0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = -1; first_rd = -1; nrd = 0; nwr = 0; data = '0; flt = 1'b0;
        for (int c = 1; c <= 10 && lat < 0; c++) begin
            @(negedge clk);
            if (MemRead) begin
                nrd++;
                if (first_rd < 0) first_rd = c;
            end
            if (MemWrite) nwr++;
            if (bus.resp_valid) begin
                lat  = c;
                data = bus.resp_data;
                flt  = bus.resp_fault;
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.resp_valid), 32'd1);
            check("hold_data", bus.resp_data, data);
            check("hold_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
    endtask

    initial begin
        int          lat, frd, nrd, nwr;
        logic [31:0] d;
        logic        f;

        bus.req_valid = 1'b0; bus.req_kind = '0; bus.req_size = 1'b0;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.resp_ready = 1'b0;

        #2;
        check("rst_ir", ir, 32'h0);
        check("rst_memrd", 32'(MemRead), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        load_mem = 1'b0;
        check("ready_after_rst", 32'(bus.req_ready), 32'd1);

        do_req(2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 0, lat, frd, nrd, nwr, d, f);
        check("fetch_lat", lat, 2);
        check("fetch_rd_cycle", frd, 1);
        check("fetch_data", d, 32'h20040005);
        check("fetch_ir", ir, 32'h20040005);
        check("fetch_fault", 32'(f), 32'd0);

        do_req(2'd2, 1'b0, 1'b0, 32'h80, 32'hDEADBEEF, 0, lat, frd, nrd, nwr, d, f);
        check("store_lat", lat, 2);
        check("store_wr_pulses", nwr, 1);
        check("store_reads", nrd, 0);
        check("store_data", d, 32'h0);
        check("store_mem", mem[32], 32'hDEADBEEF);

        do_req(2'd1, 1'b0, 1'b0, 32'h80, 32'h0, 0, lat, frd, nrd, nwr, d, f);
        check("load_data", d, 32'hDEADBEEF);
        check("load_mdr", mdr, 32'hDEADBEEF);

        do_req(2'd1, 1'b0, 1'b0, 32'h82, 32'h0, 0, lat, frd, nrd, nwr, d, f);
        check("misalign_lat", lat, 1);
        check("misalign_fault", 32'(f), 32'd1);
        check("misalign_access", nrd + nwr, 0);
        check("misalign_mdr", mdr, 32'hDEADBEEF);

        do_req(2'd1, 1'b0, 1'b0, 32'h400, 32'h0, 0, lat, frd, nrd, nwr, d, f);
        check("range_fault", 32'(f), 32'd1);
        check("range_access", nrd + nwr, 0);

        do_req(2'd3, 1'b0, 1'b0, 32'h0, 32'h0, 0, lat, frd, nrd, nwr, d, f);
        check("kind3_fault", 32'(f), 32'd1);

        do_req(2'd0, 1'b1, 1'b0, 32'h40, 32'h0, 0, lat, frd, nrd, nwr, d, f);
        check("fetch_byte_fault", 32'(f), 32'd1);

`ifdef MEM_BYTE_EN
        do_req(2'd2, 1'b1, 1'b0, 32'h41, 32'h000000AA, 0, lat, frd, nrd, nwr, d, f);
        check("bstore_lat", lat, 3);
        check("bstore_rd", nrd, 1);
        check("bstore_wr", nwr, 1);
        check("bstore_mem", mem[16], 32'h1122AA44);

        do_req(2'd1, 1'b1, 1'b0, 32'h41, 32'h0, 0, lat, frd, nrd, nwr, d, f);
        check("bload_signed", d, 32'hFFFFFFAA);
        check("bload_signed_mdr", mdr, 32'hFFFFFFAA);
        do_req(2'd1, 1'b1, 1'b1, 32'h41, 32'h0, 0, lat, frd, nrd, nwr, d, f);
        check("bload_unsigned", d, 32'h000000AA);
`else
        do_req(2'd1, 1'b1, 1'b0, 32'h41, 32'h0, 0, lat, frd, nrd, nwr, d, f);
        check("byte_disabled_fault", 32'(f), 32'd1);
        check("byte_disabled_access", nrd + nwr, 0);
`endif

        do_req(2'd1, 1'b0, 1'b0, 32'h80, 32'h0, 5, lat, frd, nrd, nwr, d, f);
        check("stall_data", d, 32'hDEADBEEF);
        @(negedge clk);
        check("ready_after_resp", 32'(bus.req_ready), 32'd1);

        // Store to 0x84 interrupted by reset while MemWrite is high.
        bus.req_kind = 2'd2; bus.req_size = 1'b0; bus.req_addr = 32'h84;
        bus.req_wdata = 32'h12345678; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("mid_memwrite", 32'(MemWrite), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("rst_memwrite", 32'(MemWrite), 32'd0);
        check("rst_addr", Address, 32'h0);
        check("rst_wdata", Write_data, 32'h0);
        check("rst_mdr", mdr, 32'h0);
        check("rst_ir_mid", ir, 32'h0);
        check("rst_valid_mid", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        check("abandoned_store", mem[33], 32'h0);
        @(negedge clk);
        check("ready_after_rst2", 32'(bus.req_ready), 32'd1);

        do_req(2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 0, lat, frd, nrd, nwr, d, f);
        check("fetch_after_rst", d, 32'h20040005);

        check("rd_wr_overlap", overlap, 0);
        check("idle_bus_nonzero", idle_bus, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: RAM_SIZE_BIT, 8, word-index width; legal byte addresses are 0 .. 4*2^RAM_SIZE_BIT-1.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low.
- req_valid  in  1  request offered.
- req_ready  out  1  unit accepts request.
- req_kind  in  2  0=FETCH, 1=LOAD, 2=STORE, 3=reserved.
- req_size  in  1  0=word, 1=byte.
- req_unsigned  in  1  byte load zero-extends when 1.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data (byte store uses bits 7:0).
- resp_valid  out  1  response available.
- resp_ready  in  1  requester takes response.
- resp_data  out  32  loaded or fetched word; 0 for STORE.
- resp_fault  out  1  request rejected, no memory access made.
- ir  out  32  instruction register.
- mdr  out  32  memory data register.
- Address  out  32  to memory, word-aligned.
- Write_data  out  32  to memory.
- MemRead  out  1  to memory.
- MemWrite  out  1  to memory.
- Mem_data  in  32  combinational read data from memory.

Function
REQ-003 FSM states SHALL be IDLE, READ, RMW, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-004 Handshake SHALL occur on the edge where req_valid && req_ready; request fields SHALL be latched then.
REQ-005 Fault SHALL be: kind 3, or word access with req_addr[1:0] != 0, or FETCH with size byte, or req_addr >= 4*2^RAM_SIZE_BIT.
- Faulting request goes IDLE->RESP with resp_fault=1; MemRead/MemWrite never asserted; ir/mdr unchanged.
REQ-006 Word FETCH/LOAD: IDLE->READ->RESP.
- READ drives MemRead=1 and Address={addr[31:2],2'b00}; Mem_data captured at the end of READ into ir (FETCH) or mdr (LOAD).
- resp_valid is first high 2 cycles after the handshake.
REQ-007 Word STORE: IDLE->WRITE->RESP.
- WRITE drives MemWrite=1 for exactly one cycle with Write_data=req_wdata.
REQ-008 Byte lanes SHALL be little-endian: addr[1:0]=n selects bits 8n+7:8n.
REQ-009 RESP SHALL hold resp_valid, resp_data and resp_fault stable until resp_ready; return to IDLE on resp_valid && resp_ready.
REQ-010 MemRead and MemWrite SHALL never be high in the same cycle, and SHALL be 0 outside READ/RMW/WRITE.
REQ-011 Address and Write_data SHALL be 0 whenever MemRead and MemWrite are both 0.
REQ-012 resp_data SHALL equal ir for FETCH, mdr for LOAD, and 0 for STORE or fault.

Reset
REQ-013 reset low SHALL immediately force IDLE, ir=0, mdr=0, resp_valid=0, resp_fault=0, MemRead=0, MemWrite=0, Address=0, Write_data=0, including mid-operation; an in-flight store is abandoned, not completed.
REQ-014 req_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-015 With MEM_BYTE_EN defined, byte accesses SHALL be supported:
- Byte LOAD: READ->RESP; mdr gets the selected byte, sign- or zero-extended per req_unsigned.
- Byte STORE: RMW (MemRead=1, word captured)->WRITE (merged word, MemWrite=1)->RESP; resp_valid is first high 3 cycles after the handshake.
REQ-016 Without MEM_BYTE_EN, any req_size=1 request SHALL fault per REQ-005; the RMW state is not built.

Structure
REQ-017 Package mem_access_pkg SHALL hold the req_kind encoding, the FSM state enum, and the byte-lane select/extend function.
REQ-018 Sub-module mem_byte_lane SHALL perform lane extract/extend and store merge; it is instantiated only under MEM_BYTE_EN.

Verification
REQ-019 Bench SHALL cover these directed scenarios:
- FETCH addr 0x0 with memory word 0x20040005 -> MemRead high 1 cycle after handshake; ir=resp_data=0x20040005 2 cycles after handshake; fault 0.
- STORE 0x80 data 0xDEADBEEF, then LOAD 0x80 -> one MemWrite pulse; the load returns mdr=0xDEADBEEF.
- LOAD 0x82 with word size -> resp_fault=1 one cycle after handshake; no MemRead/MemWrite; mdr unchanged. Repeat with addr 0x400 (RAM_SIZE_BIT=8) -> fault.
- With MEM_BYTE_EN, word 0x11223344 at 0x40: byte STORE 0x41 data 0xAA -> word becomes 0x1122AA44. Then byte LOAD 0x41 signed -> 0xFFFFFFAA; unsigned -> 0x000000AA.
- resp_ready held low 5 cycles -> resp_valid/resp_data stable and req_ready=0 throughout.
- reset pulsed low during WRITE -> MemWrite drops asynchronously and all outputs return to 0.
